// File: rtl/m4_mem_wctrl_im_pack.sv
// m4_mem_wctrl_im_pack: M4 SRAM write controller for the IM EEPROM -> SRAM restore path.
// Unpacks the EEPROM byte stream LSB-first into 13-bit coefficients, pairs them into
// 32-bit words {3'b0, v_odd, 3'b0, v_even} and writes one word per M4 memory slot
// through a 2-entry word FIFO. One group = 13 bytes = 8 coefficients = 4 words.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   copy_from_im      restore mode enable; low aborts like rst
//   start             1-cycle pulse, begins a transfer when idle
//   im_32byte_num     base group number (latched at start)
//   im_ope_vadrs/hadrs vertical/horizontal op address, [1:0] latched at start
//   im_wdata, im_wstr EEPROM byte and its valid; taken when im_wstr & im_rdy
//   m4_cmd_cycle_stp  M4 memory slot strobe, at most one write per strobe
//   im_rdy            block accepts a byte this cycle
//   we, wad, wdata    registered SRAM write port
//   busy, done        transfer in progress / 1-cycle completion pulse
module m4_mem_wctrl_im_pack #(
    parameter int NUM_GROUPS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        copy_from_im,
    input  logic        start,
    input  logic [10:0] im_32byte_num,
    input  logic [3:0]  im_ope_vadrs,
    input  logic [3:0]  im_ope_hadrs,
    input  logic [7:0]  im_wdata,
    input  logic        im_wstr,
    input  logic        m4_cmd_cycle_stp,
    output logic        im_rdy,
    output logic        we,
    output logic [18:0] wad,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done
);
    localparam logic [14:0] TOTAL = 15'(13 * NUM_GROUPS);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [10:0] base_q, base_d;
    logic [1:0]  vad_q, vad_d, had_q, had_d;
    logic [14:0] bytes_q, bytes_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [19:0] acc_q, acc_d;
    logic [4:0]  nb_q, nb_d;
    logic [12:0] half_q, half_d;
    logic        half_v_q, half_v_d;
    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic        wp_q, wp_d, rp_q, rp_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [10:0] gidx_q, gidx_d;
    logic [1:0]  wrd_q, wrd_d;
    logic        we_q, we_d;
    logic [18:0] wad_q, wad_d;
    logic [31:0] wdata_q, wdata_d;

    logic        take, emit, push, pop;
    logic [19:0] cat;
    logic [4:0]  nb8;

    always_comb begin
        im_rdy  = (state_q == S_RUN) && (cnt_q != 2'd2) && (bytes_q < TOTAL);
        take    = im_rdy & im_wstr;
        // nb never exceeds 12 before an append, so the byte always fits in 20 bits
        cat     = acc_q | (20'(im_wdata) << nb_q);
        nb8     = nb_q + 5'd8;
        emit    = take && (nb8 >= 5'd13);
        push    = emit & half_v_q;
        pop     = m4_cmd_cycle_stp && (cnt_q != 2'd0);
        state_d = state_q;
        base_d  = base_q;
        vad_d   = vad_q;
        had_d   = had_q;
        bytes_d = bytes_q;
        bcnt_d  = bcnt_q;
        acc_d   = acc_q;
        nb_d    = nb_q;
        half_d  = half_q;
        half_v_d = half_v_q;
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        gidx_d  = gidx_q;
        wrd_d   = wrd_q;
        we_d    = pop;
        wad_d   = wad_q;
        wdata_d = wdata_q;
        if (take) begin
            bytes_d = bytes_q + 15'd1;
            bcnt_d  = (bcnt_q == 4'd12) ? 4'd0 : bcnt_q + 4'd1;
            acc_d   = emit ? cat >> 13 : cat;
            nb_d    = emit ? nb8 - 5'd13 : nb8;
        end
        if (emit) begin
            half_d   = half_v_q ? half_q : cat[12:0];
            half_v_d = ~half_v_q;
        end
        if (push) begin
            mem_d[wp_q] = {3'b0, cat[12:0], 3'b0, half_q};
            wp_d        = ~wp_q;
        end
        if (pop) begin
            rp_d    = ~rp_q;
            wad_d   = {vad_q, had_q, base_q + gidx_q, 2'b00, wrd_q};
            wdata_d = mem_q[rp_q];
            wrd_d   = wrd_q + 2'd1;
            gidx_d  = (wrd_q == 2'd3) ? gidx_q + 11'd1 : gidx_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_RUN;
                base_d   = im_32byte_num;
                vad_d    = im_ope_vadrs[1:0];
                had_d    = im_ope_hadrs[1:0];
                bytes_d  = '0;
                bcnt_d   = '0;
                acc_d    = '0;
                nb_d     = '0;
                half_v_d = 1'b0;
                gidx_d   = '0;
                wrd_d    = '0;
            end
            S_RUN:   if (take && bytes_q == TOTAL - 15'd1) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == 2'd0) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !copy_from_im) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            vad_q    <= '0;
            had_q    <= '0;
            bytes_q  <= '0;
            bcnt_q   <= '0;
            acc_q    <= '0;
            nb_q     <= '0;
            half_q   <= '0;
            half_v_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= '0;
            gidx_q   <= '0;
            wrd_q    <= '0;
            we_q     <= 1'b0;
            wad_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            vad_q    <= vad_d;
            had_q    <= had_d;
            bytes_q  <= bytes_d;
            bcnt_q   <= bcnt_d;
            acc_q    <= acc_d;
            nb_q     <= nb_d;
            half_q   <= half_d;
            half_v_q <= half_v_d;
            mem_q    <= mem_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            gidx_q   <= gidx_d;
            wrd_q    <= wrd_d;
            we_q     <= we_d;
            wad_q    <= wad_d;
            wdata_q  <= wdata_d;
        end
    end

    assign we    = we_q;
    assign wad   = wad_q;
    assign wdata = wdata_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done  = (state_q == S_DONE);

    // 13 bytes carry exactly 8 coefficients, so the accumulator is empty at each group end
    a_group_align: assert property (@(posedge clk) disable iff (rst || !copy_from_im)
        (take && bcnt_q == 4'd12) |=> (nb_q == 5'd0));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || !copy_from_im)
        !(push && cnt_q == 2'd2));
endmodule
